// File: rtl/fifo_async_lvl.sv
`timescale 1ns/1ps
// Dual-clock FIFO crossing Gray-coded pointers through SYNC_STAGES-deep synchronisers,
// with fill levels and almost flags in both domains and an optional FWFT read port.
module fifo_async_lvl #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FWFT        = 0,
  parameter int AF_LVL      = 14,
  parameter int AE_LVL      = 2
) (
  input  logic                  wr_clk_i,
  input  logic                  rd_clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  full_o,
  output logic                  almost_full_o,
  output logic [ADDR_WIDTH:0]   wr_level_o,
  output logic                  wr_error_o,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rd_valid_o,
  output logic                  empty_o,
  output logic                  almost_empty_o,
  output logic [ADDR_WIDTH:0]   rd_level_o,
  output logic                  rd_error_o
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] C_DEPTH  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] C_AF     = (ADDR_WIDTH+1)'(AF_LVL);
  localparam logic [ADDR_WIDTH:0] C_AE     = (ADDR_WIDTH+1)'(AE_LVL);
  localparam logic                C_AF_RST = (AF_LVL == 0);

  if (ADDR_WIDTH < 2) begin : g_chk_aw
    $error("fifo_async_lvl: ADDR_WIDTH must be >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("fifo_async_lvl: SYNC_STAGES must be >= 2");
  end
  if (!(AE_LVL >= 0 && AE_LVL < AF_LVL && AF_LVL <= DEPTH)) begin : g_chk_lvl
    $error("fifo_async_lvl: need 0 <= AE_LVL < AF_LVL <= DEPTH");
  end

  function automatic logic [ADDR_WIDTH:0] bin2gray(input logic [ADDR_WIDTH:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
    logic [ADDR_WIDTH:0] b;
    b[ADDR_WIDTH] = g[ADDR_WIDTH];
    for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [ADDR_WIDTH:0] r_wr_bin;
  logic [ADDR_WIDTH:0] r_wr_gray;
  logic [ADDR_WIDTH:0] r_rd_bin;
  logic [ADDR_WIDTH:0] r_rd_gray;
  logic [ADDR_WIDTH:0] r_rd_gray_sync [SYNC_STAGES];
  logic [ADDR_WIDTH:0] r_wr_gray_sync [SYNC_STAGES];

  logic                w_do_write;
  logic [ADDR_WIDTH:0] w_wr_bin_next;
  logic [ADDR_WIDTH:0] w_rd_bin_sync;
  logic [ADDR_WIDTH:0] w_wr_level_next;

  always_comb begin
    w_do_write      = wr_en_i & ~full_o;
    w_wr_bin_next   = r_wr_bin + {{ADDR_WIDTH{1'b0}}, w_do_write};
    w_rd_bin_sync   = gray2bin(r_rd_gray_sync[SYNC_STAGES-1]);
    w_wr_level_next = w_wr_bin_next - w_rd_bin_sync;
  end

  always_ff @(posedge wr_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_bin      <= '0;
      r_wr_gray     <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_rd_gray_sync[i] <= '0;
      end
      full_o        <= 1'b0;
      almost_full_o <= C_AF_RST;
      wr_level_o    <= '0;
      wr_error_o    <= 1'b0;
    end else begin
      r_wr_bin          <= w_wr_bin_next;
      r_wr_gray         <= bin2gray(w_wr_bin_next);
      r_rd_gray_sync[0] <= r_rd_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_rd_gray_sync[i] <= r_rd_gray_sync[i-1];
      end
      full_o        <= (w_wr_level_next == C_DEPTH);
      almost_full_o <= (w_wr_level_next >= C_AF);
      wr_level_o    <= w_wr_level_next;
      wr_error_o    <= wr_en_i & full_o;
    end
  end

  // Storage is deliberately left out of reset so it can map onto RAM.
  always_ff @(posedge wr_clk_i) begin
    if (w_do_write) begin
      r_mem[r_wr_bin[ADDR_WIDTH-1:0]] <= wdata_i;
    end
  end

  logic [ADDR_WIDTH:0] w_wr_bin_sync;
  logic [ADDR_WIDTH:0] w_ram_level;
  logic [ADDR_WIDTH:0] w_rd_bin_next;
  logic [ADDR_WIDTH:0] w_rd_level_next;
  logic                w_do_read;
  logic                w_pop;
  logic                w_out_valid_next;

  // In FWFT mode the output register holds the head word; ~empty_o is its valid bit,
  // and the RAM pointer advances when that register loads rather than when it is popped.
  always_comb begin
    w_wr_bin_sync    = gray2bin(r_wr_gray_sync[SYNC_STAGES-1]);
    w_ram_level      = w_wr_bin_sync - r_rd_bin;
    w_pop            = 1'b0;
    w_out_valid_next = 1'b0;
    w_do_read        = 1'b0;
    if (FWFT != 0) begin
      w_pop            = rd_en_i & ~empty_o;
      w_do_read        = (empty_o | w_pop) & (w_ram_level != '0);
      w_out_valid_next = w_do_read | (~empty_o & ~w_pop);
    end else begin
      w_do_read = rd_en_i & ~empty_o;
    end
    w_rd_bin_next   = r_rd_bin + {{ADDR_WIDTH{1'b0}}, w_do_read};
    w_rd_level_next = w_wr_bin_sync - w_rd_bin_next + {{ADDR_WIDTH{1'b0}}, w_out_valid_next};
  end

  always_ff @(posedge rd_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_bin       <= '0;
      r_rd_gray      <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_wr_gray_sync[i] <= '0;
      end
      rdata_o        <= '0;
      rd_valid_o     <= 1'b0;
      empty_o        <= 1'b1;
      almost_empty_o <= 1'b1;
      rd_level_o     <= '0;
      rd_error_o     <= 1'b0;
    end else begin
      r_rd_bin          <= w_rd_bin_next;
      r_rd_gray         <= bin2gray(w_rd_bin_next);
      r_wr_gray_sync[0] <= r_wr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_wr_gray_sync[i] <= r_wr_gray_sync[i-1];
      end
      if (w_do_read) begin
        rdata_o <= r_mem[r_rd_bin[ADDR_WIDTH-1:0]];
      end
      if (FWFT != 0) begin
        rd_valid_o <= w_out_valid_next;
        empty_o    <= ~w_out_valid_next;
      end else begin
        rd_valid_o <= w_do_read;
        empty_o    <= (w_rd_level_next == '0);
      end
      almost_empty_o <= (w_rd_level_next <= C_AE);
      rd_level_o     <= w_rd_level_next;
      rd_error_o     <= rd_en_i & empty_o;
    end
  end

endmodule
